fifo_vr: RTL and testbench
==========================

Name: fifo_vr

Overview:
Next-generation general-purpose FIFO with a val/rdy handshake on both sides. It supports any depth (not restricted to powers of 2), an exposed occupancy count, and almost-full/almost-empty flags. Optional bypass and pipe modes cut one cycle of latency or allow enqueue while full. It is the drop-in buffer for decoupling pipeline stages and credit-tracked queues across the core.

Parameters:
p_entry_bits  32  width of each entry in bits
p_depth       6   number of entries; any integer >= 1
p_bypass      0   1: an enqueue into an empty FIFO appears on deq in the same cycle
p_pipe        0   1: enqueue accepted while full if a dequeue fires in the same cycle
p_afull       p_depth-1  almost_full asserted when count >= p_afull
p_aempty      1   almost_empty asserted when count <= p_aempty

Ports:
clk           in   1                     clock; all state updates on posedge
rst           in   1                     reset; active-low (0 = reset), asynchronous assert
clear         in   1                     synchronous flush
enq_val       in   1                     enqueue valid
enq_rdy       out  1                     enqueue ready
enq_msg       in   p_entry_bits          enqueue data
deq_val       out  1                     dequeue valid
deq_rdy       in   1                     dequeue ready
deq_msg       out  p_entry_bits          dequeue data (head entry, or enq_msg in bypass)
count         out  $clog2(p_depth+1)     number of stored entries
almost_full   out  1                     count >= p_afull
almost_empty  out  1                     count <= p_aempty

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset:
  - While rst=0: rptr=0, wptr=0, count=0, deq_val=0, enq_rdy=0, almost_empty=1, almost_full=(p_afull==0).
  - Storage array is not reset.
  - enq_rdy rises combinationally once rst=1.
  - Reset asserted mid-transfer discards all contents immediately, with no clock required.
- Handshake:
  - enq_fire = enq_val & enq_rdy.
  - deq_fire = deq_val & deq_rdy.
  - deq_val must not depend combinationally on deq_rdy.
  - deq_msg is don't-care when deq_val=0.
- Pointers:
  - Binary indices 0..p_depth-1.
  - Increment wraps from p_depth-1 to 0 explicitly, with no power-of-2 masking.
  - Full/empty are decided by count, never by pointer comparison.
- count update each cycle:
  - +1 on enq-only, -1 on deq-only.
  - Unchanged on both or neither.
  - Never exceeds p_depth; never underflows.
- Normal mode (p_bypass=0, p_pipe=0):
  - enq_rdy = (count < p_depth).
  - deq_val = (count > 0).
  - deq_msg = arr[rptr].
  - Minimum latency 1 cycle (enqueue at edge N, visible on deq after edge N).
- Bypass mode (p_bypass=1):
  - When count==0, deq_val = enq_val and deq_msg = enq_msg (combinational).
  - If deq_fire also occurs, nothing is written and count stays 0.
  - If deq_rdy=0, the entry is written normally.
- Pipe mode (p_pipe=1):
  - When count==p_depth, enq_rdy = deq_rdy.
  - Simultaneous enq/deq when full overwrites the slot being freed; count stays p_depth.
- Simultaneous enq and deq at any occupancy:
  - Write arr[wptr] and advance both pointers.
  - Data order is preserved strictly FIFO.
- clear=1 (synchronous):
  - Next edge sets rptr=wptr=0 and count=0.
  - Overrides any enq/deq that cycle.
  - enq_rdy=0 and deq_val=0 while clear=1, so no fire is reported.
- Flags:
  - almost_full and almost_empty are combinational from registered count.
  - Both may be high simultaneously when thresholds overlap.
- p_depth=1: single register; behaviour is identical to the rules above.
- Target size: 150-250 lines of RTL.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, release → enq_rdy=1, deq_val=0, count=0, almost_empty=1. Assert rst=0 asynchronously with count=3 → count=0 and deq_val=0 before the next edge.
- Fill/drain, non-power-of-2 wrap (p_depth=6): enqueue 0x10..0x15 with deq_rdy=0 → count=6, enq_rdy=0, almost_full=1 at count 5. Then dequeue all → order 0x10..0x15. Repeat 3 fills to exercise wrap at index 5→0.
- Simultaneous traffic: hold enq_val=deq_rdy=1 for 20 cycles at count=3 with random data → count stays 3 and output sequence equals input sequence delayed by 3 transfers.
- Bypass (p_bypass=1): empty FIFO, enq 0xAB with deq_rdy=1 → deq_val=1 and deq_msg=0xAB in the same cycle, count stays 0. With deq_rdy=0 → count=1 after the edge.
- Pipe (p_pipe=1): full at 6, enq 0x99 with deq_rdy=1 → head dequeued, count stays 6, 0x99 emerges after 5 more dequeues. With deq_rdy=0 → enq_rdy=0.
- Clear: count=4, assert clear with enq_val=deq_rdy=1 → no fire, next cycle count=0, deq_val=0. Then enq 0x01 → deq_msg=0x01 from index 0.

Source files
------------

// File: rtl/fifo_vr.sv
// Val/rdy FIFO of arbitrary depth with occupancy count, almost-full/almost-empty
// flags, and optional bypass (zero-latency when empty) and pipe (enqueue while full) modes.
module fifo_vr #(
    parameter int p_entry_bits = 32,
    parameter int p_depth      = 6,
    parameter int p_bypass     = 0,
    parameter int p_pipe       = 0,
    parameter int p_afull      = p_depth - 1,
    parameter int p_aempty     = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            enq_val,
    output logic                            enq_rdy,
    input  logic [p_entry_bits-1:0]         enq_msg,
    output logic                            deq_val,
    input  logic                            deq_rdy,
    output logic [p_entry_bits-1:0]         deq_msg,
    output logic [$clog2(p_depth+1)-1:0]    count,
    output logic                            almost_full,
    output logic                            almost_empty
);
    localparam int CW = $clog2(p_depth + 1);
    localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;

    logic [p_entry_bits-1:0] arr_q [p_depth];
    logic [PW-1:0]           rptr_q, rptr_d;
    logic [PW-1:0]           wptr_q, wptr_d;
    logic [CW-1:0]           count_q, count_d;

    logic empty, full;
    logic enq_fire, deq_fire, bypass_fire;
    logic do_write, do_read;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(p_depth));

    // Handshake: a transfer happens on a side exactly when val and rdy are both
    // high at the rising edge. deq_val never looks at deq_rdy; in pipe mode only
    // enq_rdy may look at deq_rdy. Both sides are held off during reset and clear.
    assign enq_rdy = rst && !clear && (!full || ((p_pipe != 0) && deq_rdy));
    assign deq_val = rst && !clear && (!empty || ((p_bypass != 0) && enq_val));
    assign deq_msg = ((p_bypass != 0) && empty) ? enq_msg : arr_q[rptr_q];

    assign enq_fire    = enq_val && enq_rdy;
    assign deq_fire    = deq_val && deq_rdy;
    // An entry that passes straight through never touches storage.
    assign bypass_fire = (p_bypass != 0) && empty && enq_fire && deq_fire;
    assign do_write    = enq_fire && !bypass_fire;
    assign do_read     = deq_fire && !bypass_fire;

    assign count        = count_q;
    assign almost_full  = (count_q >= CW'(p_afull));
    assign almost_empty = (count_q <= CW'(p_aempty));

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (clear) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_write) begin
                wptr_d = (wptr_q == PW'(p_depth - 1)) ? '0 : wptr_q + PW'(1);
            end
            if (do_read) begin
                rptr_d = (rptr_q == PW'(p_depth - 1)) ? '0 : rptr_q + PW'(1);
            end
            if (do_write && !do_read) begin
                count_d = count_q + CW'(1);
            end else if (do_read && !do_write) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately unreset; a full-and-dequeuing pipe write lands
    // in the slot being freed because wptr equals rptr when full.
    always_ff @(posedge clk) begin
        if (do_write) begin
            arr_q[wptr_q] <= enq_msg;
        end
    end
endmodule

// File: tb/tb_fifo_vr.sv
// Scoreboard bench for fifo_vr: normal, bypass and pipe instances share clock,
// reset and clear; per-instance monitors pop expected data on every dequeue.
module tb_fifo_vr;
    logic clk;
    logic rst;
    logic clear;

    logic        n_enq_val, n_enq_rdy, n_deq_val, n_deq_rdy, n_af, n_ae;
    logic [31:0] n_enq_msg, n_deq_msg;
    logic [2:0]  n_count;
    logic        b_enq_val, b_enq_rdy, b_deq_val, b_deq_rdy, b_af, b_ae;
    logic [31:0] b_enq_msg, b_deq_msg;
    logic [2:0]  b_count;
    logic        p_enq_val, p_enq_rdy, p_deq_val, p_deq_rdy, p_af, p_ae;
    logic [31:0] p_enq_msg, p_deq_msg;
    logic [2:0]  p_count;

    logic [31:0] exp_n[$];
    logic [31:0] exp_b[$];
    logic [31:0] exp_p[$];

    int n_checks = 0;
    int n_fail   = 0;

    fifo_vr #(.p_entry_bits(32), .p_depth(6)) u_norm (
        .clk(clk), .rst(rst), .clear(clear),
        .enq_val(n_enq_val), .enq_rdy(n_enq_rdy), .enq_msg(n_enq_msg),
        .deq_val(n_deq_val), .deq_rdy(n_deq_rdy), .deq_msg(n_deq_msg),
        .count(n_count), .almost_full(n_af), .almost_empty(n_ae)
    );

    fifo_vr #(.p_entry_bits(32), .p_depth(6), .p_bypass(1)) u_byp (
        .clk(clk), .rst(rst), .clear(clear),
        .enq_val(b_enq_val), .enq_rdy(b_enq_rdy), .enq_msg(b_enq_msg),
        .deq_val(b_deq_val), .deq_rdy(b_deq_rdy), .deq_msg(b_deq_msg),
        .count(b_count), .almost_full(b_af), .almost_empty(b_ae)
    );

    fifo_vr #(.p_entry_bits(32), .p_depth(6), .p_pipe(1)) u_pipe (
        .clk(clk), .rst(rst), .clear(clear),
        .enq_val(p_enq_val), .enq_rdy(p_enq_rdy), .enq_msg(p_enq_msg),
        .deq_val(p_deq_val), .deq_rdy(p_deq_rdy), .deq_msg(p_deq_msg),
        .count(p_count), .almost_full(p_af), .almost_empty(p_ae)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitors: every dequeue handshake is compared against the expected queue
    always @(negedge clk) begin
        if (n_deq_val && n_deq_rdy) begin
            if (exp_n.size() == 0) check("n_deq_unexpected", n_deq_msg, 32'hDEAD_BEEF);
            else check("n_deq_msg", n_deq_msg, exp_n.pop_front());
        end
    end

    always @(negedge clk) begin
        if (b_deq_val && b_deq_rdy) begin
            if (exp_b.size() == 0) check("b_deq_unexpected", b_deq_msg, 32'hDEAD_BEEF);
            else check("b_deq_msg", b_deq_msg, exp_b.pop_front());
        end
    end

    always @(negedge clk) begin
        if (p_deq_val && p_deq_rdy) begin
            if (exp_p.size() == 0) check("p_deq_unexpected", p_deq_msg, 32'hDEAD_BEEF);
            else check("p_deq_msg", p_deq_msg, exp_p.pop_front());
        end
    end

    // driver tasks
    task automatic enq_norm(input logic [31:0] d);
        n_enq_val = 1'b1;
        n_enq_msg = d;
        exp_n.push_back(d);
        @(negedge clk);
        check("n_enq_rdy", {31'b0, n_enq_rdy}, 32'd1);
        step();
        n_enq_val = 1'b0;
    endtask

    task automatic enq_pipe(input logic [31:0] d);
        p_enq_val = 1'b1;
        p_enq_msg = d;
        exp_p.push_back(d);
        @(negedge clk);
        check("p_enq_rdy", {31'b0, p_enq_rdy}, 32'd1);
        step();
        p_enq_val = 1'b0;
    endtask

    task automatic drain_norm();
        logic done;
        done = 1'b0;
        n_deq_rdy = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (n_count == 3'd0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("n_drain_done", {31'b0, done}, 32'd1);
        step();
        n_deq_rdy = 1'b0;
    endtask

    task automatic drain_pipe();
        logic done;
        done = 1'b0;
        p_deq_rdy = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (p_count == 3'd0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("p_drain_done", {31'b0, done}, 32'd1);
        step();
        p_deq_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0;
        n_enq_val = 0; n_enq_msg = 0; n_deq_rdy = 0;
        b_enq_val = 0; b_enq_msg = 0; b_deq_rdy = 0;
        p_enq_val = 0; p_enq_msg = 0; p_deq_rdy = 0;

        // reset held for 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_enq_rdy", {31'b0, n_enq_rdy}, 32'd0);
        check("rst_deq_val", {31'b0, n_deq_val}, 32'd0);
        check("rst_count", {29'b0, n_count}, 32'd0);
        check("rst_ae", {31'b0, n_ae}, 32'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("idle_enq_rdy", {31'b0, n_enq_rdy}, 32'd1);
        check("idle_deq_val", {31'b0, n_deq_val}, 32'd0);
        check("idle_count", {29'b0, n_count}, 32'd0);
        check("idle_ae", {31'b0, n_ae}, 32'd1);
        check("idle_af", {31'b0, n_af}, 32'd0);
        step();

        // offset pointers by one so fills wrap mid-array
        enq_norm(32'h0F);
        drain_norm();

        // three fill/drain rounds through index 5 -> 0
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) begin
                check("fill_count", {29'b0, n_count}, i);
                check("fill_af", {31'b0, n_af}, (i >= 5) ? 32'd1 : 32'd0);
                enq_norm(32'h10 + r * 32'h100 + i);
            end
            @(negedge clk);
            check("full_count", {29'b0, n_count}, 32'd6);
            check("full_enq_rdy", {31'b0, n_enq_rdy}, 32'd0);
            check("full_af", {31'b0, n_af}, 32'd1);
            check("full_ae", {31'b0, n_ae}, 32'd0);
            step();
            drain_norm();
        end

        // simultaneous enq/deq at count 3
        for (int i = 0; i < 3; i++) enq_norm(32'hA0 + i);
        n_enq_val = 1'b1;
        n_deq_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            n_enq_msg = 32'h1000 + k * 32'h11;
            exp_n.push_back(n_enq_msg);
            @(negedge clk);
            check("steady_count", {29'b0, n_count}, 32'd3);
            step();
        end
        n_enq_val = 1'b0;
        n_deq_rdy = 1'b0;
        drain_norm();

        // clear overrides a pending enq and deq
        for (int i = 0; i < 4; i++) enq_norm(32'h40 + i);
        clear = 1'b1;
        n_enq_val = 1'b1;
        n_enq_msg = 32'h77;
        n_deq_rdy = 1'b1;
        @(negedge clk);
        check("clr_enq_rdy", {31'b0, n_enq_rdy}, 32'd0);
        check("clr_deq_val", {31'b0, n_deq_val}, 32'd0);
        step();
        clear = 1'b0;
        n_enq_val = 1'b0;
        n_deq_rdy = 1'b0;
        exp_n.delete();
        @(negedge clk);
        check("clr_count", {29'b0, n_count}, 32'd0);
        check("clr_deq_val_after", {31'b0, n_deq_val}, 32'd0);
        step();
        enq_norm(32'h01);
        @(negedge clk);
        check("clr_head_val", {31'b0, n_deq_val}, 32'd1);
        check("clr_head_msg", n_deq_msg, 32'h01);
        step();
        drain_norm();

        // asynchronous reset with three entries stored
        for (int i = 0; i < 3; i++) enq_norm(32'h50 + i);
        @(negedge clk);
        check("pre_arst_count", {29'b0, n_count}, 32'd3);
        #2;
        rst = 1'b0;
        exp_n.delete();
        #1;
        check("arst_count", {29'b0, n_count}, 32'd0);
        check("arst_deq_val", {31'b0, n_deq_val}, 32'd0);
        check("arst_enq_rdy", {31'b0, n_enq_rdy}, 32'd0);
        step();
        rst = 1'b1;
        step();

        // bypass: empty and ready passes through in the same cycle
        b_enq_val = 1'b1;
        b_enq_msg = 32'hAB;
        b_deq_rdy = 1'b1;
        exp_b.push_back(32'hAB);
        @(negedge clk);
        check("byp_deq_val", {31'b0, b_deq_val}, 32'd1);
        check("byp_deq_msg", b_deq_msg, 32'hAB);
        step();
        b_enq_val = 1'b0;
        b_deq_rdy = 1'b0;
        @(negedge clk);
        check("byp_count0", {29'b0, b_count}, 32'd0);
        step();
        b_enq_val = 1'b1;
        b_enq_msg = 32'hCD;
        exp_b.push_back(32'hCD);
        step();
        b_enq_val = 1'b0;
        @(negedge clk);
        check("byp_count1", {29'b0, b_count}, 32'd1);
        check("byp_hold_msg", b_deq_msg, 32'hCD);
        step();
        b_deq_rdy = 1'b1;
        step();
        b_deq_rdy = 1'b0;
        @(negedge clk);
        check("byp_count_end", {29'b0, b_count}, 32'd0);
        step();

        // pipe: enqueue into a full FIFO while the head leaves
        for (int i = 0; i < 6; i++) enq_pipe(32'h60 + i);
        p_enq_val = 1'b1;
        p_enq_msg = 32'h98;
        @(negedge clk);
        check("pipe_full_count", {29'b0, p_count}, 32'd6);
        check("pipe_full_rdy", {31'b0, p_enq_rdy}, 32'd0);
        step();
        p_enq_msg = 32'h99;
        p_deq_rdy = 1'b1;
        exp_p.push_back(32'h99);
        @(negedge clk);
        check("pipe_enq_rdy", {31'b0, p_enq_rdy}, 32'd1);
        step();
        p_enq_val = 1'b0;
        p_deq_rdy = 1'b0;
        @(negedge clk);
        check("pipe_count", {29'b0, p_count}, 32'd6);
        step();
        drain_pipe();

        check("n_queue_empty", exp_n.size(), 32'd0);
        check("b_queue_empty", exp_b.size(), 32'd0);
        check("p_queue_empty", exp_p.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
